mdu_sequencer: RTL and testbench
================================

// Module: mdu_sequencer
// PURPOSE
//  Multi-cycle controller for the RV64M multiply/divide unit. Accepts one mduop per start from the
//  execute stage and runs iterative radix-2 shift-add multiply or restoring divide. Returns a
//  registered 64-bit result with a done pulse. Holds the execute stage stalled via busy until then.
//  Sits beside the ALU in execute; a flush from the pipeline aborts the operation.
// PARAMETERS
//  XLEN      64   datapath width; W-ops use XLEN/2
//  MUL_ITER  64   iterations for MUL (32 used for MULW)
//  DIV_ITER  64   iterations for DIV/DIVU/REM/REMU (32 used for *W)
// PORTS
//  clk         in   1     clock
//  reset       in   1     synchronous, active-high reset
//  start       in   1     op request; accepted only when ready=1
//  mduop       in   4     mdu_op_t: MUL,MULW,DIV,DIVU,REM,REMU,DIVW,DIVUW,REMW,REMUW
//  src_a       in   64    rs1 value (dividend / multiplicand)
//  src_b       in   64    rs2 value (divisor / multiplier)
//  flush       in   1     abort current op, discard result
//  ready       out  1     1 only in IDLE
//  busy        out  1     1 from the cycle after accept through FIX; stalls execute
//  done        out  1     one-cycle pulse; result valid
//  result      out  64    final value; held stable from DONE until next accept
// BEHAVIOUR
//  Operation is one clock and one synchronous active-high reset.
//  - Reset: state=IDLE, ready=1, busy=0, done=0, result=0, counter=0, and all internal regs 0.
//  - FSM states are IDLE, MUL, DIV, FIX and DONE.
//    - IDLE -> MUL|DIV on start. Operands are latched on accept.
//    - MUL|DIV -> FIX when the counter hits 0.
//    - FIX -> DONE.
//    - DONE -> IDLE.
//  - Latency, for an accept in cycle C:
//    - Iterations run in cycles C+1..C+N. N is 64, or 32 for W-ops.
//    - FIX runs in C+N+1.
//    - done=1 in C+N+2 only.
//    - MUL takes 66 cycles to done, MULW 34, DIV 66, DIVW 34.
//  - Operand prep, done at accept and stored as magnitudes plus sign flags:
//    - W-ops use src[31:0]. DIVW/REMW sign-extend; DIVUW/REMUW zero-extend.
//    - Signed div/rem convert to absolute values and record sign_q=a^b and sign_r=a.
//  - MUL keeps the low XLEN bits of a*b; the product is identical for signed and unsigned.
//  - FIX does the following:
//    - applies sign negation to quotient and remainder;
//    - selects quotient or remainder;
//    - for W-ops, sign-extends result[31:0] to 64.
//  - Special cases bypass iteration: IDLE -> FIX on accept, so done lands in C+2.
//    - Divide by zero gives quotient=all ones and remainder=dividend (after W-extension).
//    - Signed overflow (most-negative / -1) gives quotient=dividend and remainder=0.
//  - Handshakes:
//    - start while ready=0 is ignored (no queueing).
//    - mduop and src_* are don't-care except in the accept cycle.
//  - Flush:
//    - In any state, next state is IDLE, done stays 0, and result is unchanged.
//    - flush and start in the same IDLE cycle: flush wins and nothing is accepted.
//  - Reset mid-operation: same as reset. No done is produced.
//  - Counter: loaded with N-1 on accept and decremented once per iteration cycle. It never wraps;
//    it is only read in MUL/DIV.
//  - Undefined mduop on start: accepted as MUL. The decoder guarantees a valid encoding.
// STRUCTURE
//  - Package pipes holds:
//    - mdu_op_t (shared with the decoder; add DIVU, DIVW, DIVUW, REMW, REMUW);
//    - mdu_state_t;
//    - the constants MDU_ITER_D=64 and MDU_ITER_W=32.
//  - Sub-module mdu_div_step is a combinational restoring step: it takes {rem,quo,divisor} and
//    returns next {rem,quo}. It is instantiated once.
//  - The multiply step stays inline: it is an add and a shift.
// TESTING
//  1. MUL a=7, b=-3 -> done at C+66, result=0xFFFF_FFFF_FFFF_FFEB; busy=1 in C+1..C+65.
//  2. DIVW a=0x0000_0000_FFFF_FFF9 (-7), b=2 -> done at C+34, result=0xFFFF_FFFF_FFFF_FFFD.
//     REMW with the same operands gives result=0xFFFF_FFFF_FFFF_FFFF.
//  3. Divide-by-zero cases, each with done at C+2:
//     - DIVU a=5, b=0 -> result=0xFFFF_FFFF_FFFF_FFFF;
//     - REM a=5, b=0 -> result=5.
//  4. Overflow: DIV a=0x8000_0000_0000_0000, b=-1 -> result=0x8000_0000_0000_0000, done at C+2.
//     REM with the same operands gives 0.
//  5. Accept DIV, then assert flush at C+10 -> IDLE at C+11, ready=1, no done.
//     A new MULW 3*4 accepted at C+11 gives result=12 at C+45.
//  6. Assert reset at C+20 of a MUL -> all outputs at reset values next cycle.
//     start held during busy is ignored; the result stays stable after done until the next accept.

Source files
------------

// File: rtl/pipes.sv
// Shared MDU types and constants.
//  mdu_op_t    : operation code driven by the decoder into the multiply/divide unit
//  mdu_state_t : sequencer FSM states
//  MDU_ITER_D  : iteration count for 64-bit ops
//  MDU_ITER_W  : iteration count for W (32-bit) ops
package pipes;

  typedef enum logic [3:0] {
    MduMul   = 4'd0,
    MduMulw  = 4'd1,
    MduDiv   = 4'd2,
    MduDivu  = 4'd3,
    MduRem   = 4'd4,
    MduRemu  = 4'd5,
    MduDivw  = 4'd6,
    MduDivuw = 4'd7,
    MduRemw  = 4'd8,
    MduRemuw = 4'd9
  } mdu_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StFix,
    StDone
  } mdu_state_t;

  localparam int unsigned MDU_ITER_D = 64;
  localparam int unsigned MDU_ITER_W = 32;

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step.
//  rem_i/quo_i : partial remainder and dividend/quotient shift register
//  divisor_i   : divisor magnitude
//  rem_o/quo_o : next partial remainder and shift register (new quotient bit in LSB)
module mdu_div_step #(
  parameter int unsigned Width = 64
) (
  input  logic [Width-1:0] rem_i,
  input  logic [Width-1:0] quo_i,
  input  logic [Width-1:0] divisor_i,
  output logic [Width-1:0] rem_o,
  output logic [Width-1:0] quo_o
);

  // One extra bit: the shifted remainder can exceed Width bits before the subtract.
  logic [Width:0] rem_sh;
  logic [Width:0] diff;

  assign rem_sh = {rem_i, quo_i[Width-1]};
  assign diff   = rem_sh - {1'b0, divisor_i};

  always_comb begin
    if (diff[Width]) begin
      // Borrow: divisor did not fit, keep the shifted remainder.
      rem_o = rem_sh[Width-1:0];
      quo_o = {quo_i[Width-2:0], 1'b0};
    end else begin
      rem_o = diff[Width-1:0];
      quo_o = {quo_i[Width-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle RV64M multiply/divide sequencer: radix-2 shift-add multiply, restoring divide.
//  clk, reset      : clock, synchronous active-high reset
//  start, mduop    : op request (accepted only while ready), operation code
//  src_a, src_b    : rs1 / rs2 operands, sampled only in the accept cycle
//  flush           : abort current op; result keeps its previous value
//  ready           : idle and able to accept
//  busy            : op in flight (iterate and fix-up cycles)
//  done, result    : one-cycle done pulse; result held until next accept
module mdu_sequencer
  import pipes::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  mdu_op_t     mduop,
  input  logic [63:0] src_a,
  input  logic [63:0] src_b,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  localparam int unsigned Xlen = 64;
  localparam int unsigned Half = Xlen / 2;
  localparam int unsigned CntW = $clog2(MDU_ITER_D);

  function automatic logic op_is_w(mdu_op_t op);
    return op inside {MduMulw, MduDivw, MduDivuw, MduRemw, MduRemuw};
  endfunction

  function automatic logic op_is_mul(mdu_op_t op);
    return op inside {MduMul, MduMulw};
  endfunction

  function automatic logic op_is_rem(mdu_op_t op);
    return op inside {MduRem, MduRemu, MduRemw, MduRemuw};
  endfunction

  function automatic logic op_is_signed(mdu_op_t op);
    return op inside {MduDiv, MduRem, MduDivw, MduRemw};
  endfunction

  // hi/lo/opnd are shared: MUL uses them as accumulator/multiplier/multiplicand,
  // DIV as remainder/quotient shift register/divisor.
  mdu_state_t       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  mdu_op_t          op_q, op_d;
  logic [Xlen-1:0]  hi_q, hi_d;
  logic [Xlen-1:0]  lo_q, lo_d;
  logic [Xlen-1:0]  opnd_q, opnd_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [Xlen-1:0]  result_q, result_d;

  // Accept-cycle operand preparation.
  mdu_op_t         acc_op;
  logic            acc_w, acc_sgn, a_neg, b_neg, acc_dz, acc_ovf;
  logic [Xlen-1:0] a_ext, b_ext, a_mag, b_mag;

  always_comb begin
    // Undefined encodings fall back to MUL.
    acc_op = mduop inside {[MduMul:MduRemuw]} ? mduop : MduMul;
    acc_w  = op_is_w(acc_op);
    acc_sgn = op_is_signed(acc_op);
    if (acc_w && acc_sgn) begin
      a_ext = {{Half{src_a[Half-1]}}, src_a[Half-1:0]};
      b_ext = {{Half{src_b[Half-1]}}, src_b[Half-1:0]};
    end else if (acc_w) begin
      a_ext = {{Half{1'b0}}, src_a[Half-1:0]};
      b_ext = {{Half{1'b0}}, src_b[Half-1:0]};
    end else begin
      a_ext = src_a;
      b_ext = src_b;
    end
    a_neg   = acc_sgn & a_ext[Xlen-1];
    b_neg   = acc_sgn & b_ext[Xlen-1];
    a_mag   = a_neg ? -a_ext : a_ext;
    b_mag   = b_neg ? -b_ext : b_ext;
    acc_dz  = (b_ext == '0);
    // After sign extension both widths reduce to "dividend is the most negative value".
    acc_ovf = acc_sgn && (b_ext == '1) &&
              (acc_w ? (a_ext == {{(Half + 1){1'b1}}, {(Half - 1){1'b0}}})
                     : (a_ext == {1'b1, {(Xlen - 1){1'b0}}}));
  end

  logic [Xlen-1:0] step_rem, step_quo;

  mdu_div_step #(
    .Width(Xlen)
  ) u_div_step (
    .rem_i    (hi_q),
    .quo_i    (lo_q),
    .divisor_i(opnd_q),
    .rem_o    (step_rem),
    .quo_o    (step_quo)
  );

  // Fix-up: sign correction, quotient/remainder select, W sign extension.
  logic            fix_neg;
  logic [Xlen-1:0] fix_sel, fix_val, fix_res;

  always_comb begin
    fix_sel = (op_is_mul(op_q) || op_is_rem(op_q)) ? hi_q : lo_q;
    fix_neg = !op_is_mul(op_q) && (op_is_rem(op_q) ? neg_rem_q : neg_quo_q);
    fix_val = fix_neg ? -fix_sel : fix_sel;
    fix_res = op_is_w(op_q) ? {{Half{fix_val[Half-1]}}, fix_val[Half-1:0]} : fix_val;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d      = acc_op;
          cnt_d     = acc_w ? CntW'(MDU_ITER_W - 1) : CntW'(MDU_ITER_D - 1);
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
          if (op_is_mul(acc_op)) begin
            hi_d    = '0;
            lo_d    = src_b;
            opnd_d  = src_a;
            state_d = StMul;
          end else if (acc_dz) begin
            hi_d    = a_ext;
            lo_d    = '1;
            state_d = StFix;
          end else if (acc_ovf) begin
            hi_d    = '0;
            lo_d    = a_ext;
            state_d = StFix;
          end else begin
            hi_d      = '0;
            // W dividends sit in the upper half so 32 steps shift them fully through.
            lo_d      = acc_w ? {a_mag[Half-1:0], {Half{1'b0}}} : a_mag;
            opnd_d    = b_mag;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            state_d   = StDiv;
          end
        end
      end
      StMul: begin
        hi_d   = hi_q + (lo_q[0] ? opnd_q : '0);
        opnd_d = opnd_q << 1;
        lo_d   = lo_q >> 1;
        if (cnt_q == '0) state_d = StFix;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StDiv: begin
        hi_d = step_rem;
        lo_d = step_quo;
        if (cnt_q == '0) state_d = StFix;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StFix: begin
        result_d = fix_res;
        state_d  = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= MduMul;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign ready  = (state_q == StIdle);
  assign busy   = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed vector table, multi-cycle corner
// sequences (start while busy, flush, reset mid-op) and randomized ops against a model.
module tb_mdu_sequencer;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  mdu_op_t     mduop;
  logic [63:0] src_a, src_b;
  logic        ready, busy, done;
  logic [63:0] result;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  mdu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mduop (mduop),
    .src_a (src_a),
    .src_b (src_b),
    .flush (flush),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  typedef struct {
    mdu_op_t     op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
  endtask

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference result straight from RV64M semantics.
  function automatic logic [63:0] model_res(input mdu_op_t op, input logic [63:0] a,
                                            input logic [63:0] b);
    longint      sa, sb;
    int          sa32, sb32;
    logic [31:0] ua32, ub32, r32;
    logic [63:0] r;
    logic        ovf64, ovf32;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == '1);
    ovf32 = (ua32 == 32'h8000_0000) && (ub32 == '1);
    r = '0;
    case (op)
      MduMul:  r = a * b;
      MduMulw: begin r32 = ua32 * ub32; r = sext32(r32); end
      MduDiv:  if (b == 0) r = '1; else if (ovf64) r = a; else r = 64'(sa / sb);
      MduDivu: if (b == 0) r = '1; else r = a / b;
      MduRem:  if (b == 0) r = a; else if (ovf64) r = '0; else r = 64'(sa % sb);
      MduRemu: if (b == 0) r = a; else r = a % b;
      MduDivw: begin
        if (ub32 == 0) r32 = '1; else if (ovf32) r32 = ua32; else r32 = 32'(sa32 / sb32);
        r = sext32(r32);
      end
      MduDivuw: begin
        if (ub32 == 0) r32 = '1; else r32 = ua32 / ub32;
        r = sext32(r32);
      end
      MduRemw: begin
        if (ub32 == 0) r32 = ua32; else if (ovf32) r32 = '0; else r32 = 32'(sa32 % sb32);
        r = sext32(r32);
      end
      MduRemuw: begin
        if (ub32 == 0) r32 = ua32; else r32 = ua32 % ub32;
        r = sext32(r32);
      end
      default: r = a * b;
    endcase
    return r;
  endfunction

  // Cycles from accept to done: special divides take 2, otherwise N + 2.
  function automatic int model_lat(input mdu_op_t op, input logic [63:0] a,
                                   input logic [63:0] b);
    logic w, special;
    w = op inside {MduMulw, MduDivw, MduDivuw, MduRemw, MduRemuw};
    special = 1'b0;
    if (op inside {MduDiv, MduDivu, MduRem, MduRemu})
      special = (b == 0) ||
                ((op inside {MduDiv, MduRem}) && a == 64'h8000_0000_0000_0000 && b == '1);
    if (op inside {MduDivw, MduDivuw, MduRemw, MduRemuw})
      special = (b[31:0] == 0) ||
                ((op inside {MduDivw, MduRemw}) && a[31:0] == 32'h8000_0000 &&
                 b[31:0] == 32'hFFFF_FFFF);
    if (special) return 2;
    return w ? 34 : 66;
  endfunction

  function automatic logic [63:0] rnd_opnd();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = 64'h8000_0000_0000_0000;
      3:       v = 64'hFFFF_FFFF_8000_0000;
      4:       v = 64'($urandom_range(0, 20));
      5:       v = ~64'($urandom_range(0, 19));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Call at #1 after a posedge; returns at #1 in cycle C+1.
  task automatic accept_op(input mdu_op_t op, input logic [63:0] a, input logic [63:0] b);
    mduop = op; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mduop = mdu_op_t'(4'($urandom_range(0, 9)));
    src_a = {$urandom, $urandom};
    src_b = {$urandom, $urandom};
  endtask

  // Returns in the done cycle (or at the budget); lat counts cycles after accept.
  task automatic wait_done(output int lat, output logic busy_bad);
    lat = 1; busy_bad = 1'b0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy !== 1'b1 || ready !== 1'b0) busy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (busy !== 1'b0) busy_bad = 1'b1;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (ready !== 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
    check("ready before accept", {63'd0, ready}, 64'd1);
  endtask

  task automatic run_check(input string name, input mdu_op_t op, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp_res, input int exp_lat);
    int   lat;
    logic bb;
    wait_ready();
    accept_op(op, a, b);
    wait_done(lat, bb);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " result"}, result, exp_res);
    check({name, " busy"}, {63'd0, bb}, 64'd0);
    @(posedge clk); #1;
    check({name, " done pulse"}, {63'd0, done}, 64'd0);
    check({name, " hold"}, result, exp_res);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, cnt;
    logic bb;
    mdu_op_t     op;
    logic [63:0] a, b;

    vecs.push_back('{MduMul,   64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66});
    vecs.push_back('{MduDivw,  64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34});
    vecs.push_back('{MduRemw,  64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34});
    vecs.push_back('{MduDivu,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2});
    vecs.push_back('{MduRem,   64'd5, 64'd0, 64'd5, 2});
    vecs.push_back('{MduDiv,   64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 2});
    vecs.push_back('{MduRem,   64'h8000_0000_0000_0000, '1, 64'd0, 2});
    vecs.push_back('{MduMulw,  64'd3, 64'd4, 64'd12, 34});
    vecs.push_back('{MduDiv,   64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 66});
    vecs.push_back('{MduRem,   64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 66});
    vecs.push_back('{MduDivuw, 64'h0000_0000_8000_0000, 64'd2, 64'h0000_0000_4000_0000, 34});
    vecs.push_back('{MduRemuw, 64'h1234_5678_0000_000A, 64'hFFFF_FFFF_0000_0003, 64'd1, 34});
    vecs.push_back('{MduDivw,  64'd7, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2});
    vecs.push_back('{MduRemuw, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 2});
    vecs.push_back('{MduDivw,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                     64'hFFFF_FFFF_8000_0000, 2});
    vecs.push_back('{MduMul,   '1, '1, 64'd1, 66});
    vecs.push_back('{MduRemu,  64'd100, 64'd7, 64'd2, 66});

    reset = 1'b1; start = 1'b0; flush = 1'b0; mduop = MduMul; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset ready", {63'd0, ready}, 64'd1);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset result", result, 64'd0);

    foreach (vecs[i])
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                vecs[i].lat);

    // start held during busy must not queue a second op.
    wait_ready();
    accept_op(MduMul, 64'd9, 64'd9);
    start = 1'b1; mduop = MduDivu; src_a = 64'd100; src_b = 64'd0;
    wait_done(lat, bb);
    start = 1'b0;
    check("held start latency", 64'(lat), 64'd66);
    check("held start result", result, 64'd81);
    repeat (5) begin @(posedge clk); #1; end
    check("idle hold result", result, 64'd81);
    check("idle hold ready", {63'd0, ready}, 64'd1);

    // Flush in C+10 of a DIV, then MULW accepted in C+11.
    accept_op(MduDiv, 64'd1000, 64'd7);
    cnt = 0;
    repeat (9) begin if (done) cnt++; @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush ready", {63'd0, ready}, 64'd1);
    check("flush busy", {63'd0, busy}, 64'd0);
    check("flush no done", 64'(cnt) + {63'd0, done}, 64'd0);
    check("flush result kept", result, 64'd81);
    accept_op(MduMulw, 64'd3, 64'd4);
    wait_done(lat, bb);
    check("post-flush mulw latency", 64'(lat), 64'd34);
    check("post-flush mulw result", result, 64'd12);
    @(posedge clk); #1;

    // flush and start together in IDLE: nothing accepted.
    mduop = MduMul; src_a = 64'd2; src_b = 64'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush+start ready", {63'd0, ready}, 64'd1);
    check("flush+start busy", {63'd0, busy}, 64'd0);

    // Flush while in FIX of a divide-by-zero: no done, result untouched.
    accept_op(MduDivu, 64'd5, 64'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    cnt = 0;
    repeat (4) begin if (done) cnt++; @(posedge clk); #1; end
    check("fix flush no done", 64'(cnt), 64'd0);
    check("fix flush result", result, 64'd12);

    // Reset at C+20 of a MUL.
    accept_op(MduMul, 64'd5, 64'd5);
    repeat (19) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset ready", {63'd0, ready}, 64'd1);
    check("midreset busy", {63'd0, busy}, 64'd0);
    check("midreset done", {63'd0, done}, 64'd0);
    check("midreset result", result, 64'd0);
    reset = 1'b0;
    cnt = 0;
    repeat (70) begin if (done) cnt++; @(posedge clk); #1; end
    check("midreset no done", 64'(cnt), 64'd0);

    for (int k = 0; k < 40; k++) begin
      op = mdu_op_t'(4'($urandom_range(0, 9)));
      a  = rnd_opnd();
      b  = rnd_opnd();
      run_check($sformatf("rnd%0d op%0d a=%016h b=%016h", k, op, a, b), op, a, b,
                model_res(op, a, b), model_lat(op, a, b));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
